// File: rtl/vga_pixel_pipe_if.sv
// Framebuffer read port between the pixel pipe (master) and the shared memory (slave).
interface vga_pixel_pipe_if;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data;

  modport master (output mem_addr, output mem_rd, input mem_data);
  modport slave  (input mem_addr, input mem_rd, output mem_data);
endinterface

// File: rtl/vga_pixel_pipe.sv
// VGA pixel pipe: fetches framebuffer words, extracts rrggbb pixels and realigns syncs to
// the memory latency; keeps per-frame fetch statistics.
module vga_pixel_pipe #(
  parameter int unsigned VGA_BITS = 4,
  parameter int unsigned RD_LAT   = 1,
  parameter logic [31:0] FB_BASE  = 32'h200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hs_in,
  input  logic                vs_in,
  input  logic                da_in,
  input  logic [31:0]         vaddr_in,
  vga_pixel_pipe_if.master    mem,
  output logic [VGA_BITS-1:0] VGA_R,
  output logic [VGA_BITS-1:0] VGA_G,
  output logic [VGA_BITS-1:0] VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         fetch_cnt
);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       da;
    logic       fresh;
    logic [1:0] bsel;
  } stage_t;

  localparam stage_t StageIdle = '{hs: 1'b1, vs: 1'b1, da: 1'b0, fresh: 1'b0, bsel: 2'b00};

  function automatic logic [VGA_BITS-1:0] expand(input logic [1:0] f);
    logic [VGA_BITS-1:0] v;
    for (int i = 0; i < VGA_BITS; i++) v[VGA_BITS-1-i] = f[~i[0]];
    return v;
  endfunction

  stage_t      s0_q;
  stage_t      pipe_q [RD_LAT];
  stage_t      ds;
  logic [31:0] mem_addr_q;
  logic [29:0] last_w_q;
  logic [29:0] word;
  logic        fresh;
  logic [31:0] held_word_q;
  logic [31:0] word_sel;
  logic [5:0]  pix;
  logic [15:0] run_q;
  logic [15:0] run_inc;
  logic        frame_end;

  assign word         = vaddr_in[31:2];
  // A line start (da rising) always refetches, even if the word matches the last one.
  assign fresh        = da_in & ((word != last_w_q) | ~s0_q.da);
  assign mem.mem_rd   = s0_q.fresh;
  assign mem.mem_addr = mem_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q       <= StageIdle;
      mem_addr_q <= FB_BASE;
      last_w_q   <= '0;
    end else begin
      s0_q <= '{hs: hs_in, vs: vs_in, da: da_in, fresh: fresh, bsel: vaddr_in[1:0]};
      if (da_in) mem_addr_q <= FB_BASE + {word, 2'b00};
      if (fresh) last_w_q <= word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= StageIdle;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) pipe_q[i] <= pipe_q[i-1];
      pipe_q[0] <= s0_q;
    end
  end

  assign ds = pipe_q[RD_LAT-1];

  always_comb begin
    word_sel = ds.fresh ? mem.mem_data : held_word_q;
    pix      = '0;
    unique case (ds.bsel)
      2'd0: pix = word_sel[5:0];
      2'd1: pix = word_sel[13:8];
      2'd2: pix = word_sel[21:16];
      2'd3: pix = word_sel[29:24];
      default: pix = '0;
    endcase
  end

  // Frame ends when the registered VGA_VS is about to fall.
  assign frame_end = VGA_VS & ~ds.vs;
  assign run_inc   = (run_q == 16'hFFFF) ? run_q : run_q + {15'd0, mem.mem_rd};

  always_ff @(posedge clk) begin
    if (reset) begin
      held_word_q <= '0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      frame_cnt   <= '0;
      fetch_cnt   <= '0;
      run_q       <= '0;
    end else begin
      if (ds.fresh) held_word_q <= mem.mem_data;
      VGA_R  <= ds.da ? expand(pix[5:4]) : '0;
      VGA_G  <= ds.da ? expand(pix[3:2]) : '0;
      VGA_B  <= ds.da ? expand(pix[1:0]) : '0;
      VGA_HS <= ds.hs;
      VGA_VS <= ds.vs;
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
        fetch_cnt <= run_inc;
        run_q     <= {15'd0, mem.mem_rd};
      end else begin
        run_q <= run_inc;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Bench for vga_pixel_pipe: two instances (read latency 1 and 3) share the timing stimulus
// and are compared every cycle against a pixel-level reference model.
module tb_vga_pixel_pipe;
  localparam logic [31:0] FB   = 32'h200;
  localparam int          MAXS = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, hs_in, vs_in, da_in;
  logic [31:0] vaddr_in;

  vga_pixel_pipe_if m1 ();
  vga_pixel_pipe_if m3 ();

  logic [3:0]  r1, g1, b1, r3, g3, b3;
  logic        hs1, vs1, hs3, vs3;
  logic [15:0] fc1, fe1, fc3, fe3;

  vga_pixel_pipe #(.VGA_BITS(4), .RD_LAT(1), .FB_BASE(FB)) dut1 (
    .clk(clk), .reset(reset), .hs_in(hs_in), .vs_in(vs_in), .da_in(da_in),
    .vaddr_in(vaddr_in), .mem(m1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
    .VGA_HS(hs1), .VGA_VS(vs1), .frame_cnt(fc1), .fetch_cnt(fe1)
  );

  vga_pixel_pipe #(.VGA_BITS(4), .RD_LAT(3), .FB_BASE(FB)) dut3 (
    .clk(clk), .reset(reset), .hs_in(hs_in), .vs_in(vs_in), .da_in(da_in),
    .vaddr_in(vaddr_in), .mem(m3), .VGA_R(r3), .VGA_G(g3), .VGA_B(b3),
    .VGA_HS(hs3), .VGA_VS(vs3), .frame_cnt(fc3), .fetch_cnt(fe3)
  );

  // Memory: 64 words mirrored across the address space.
  logic [31:0] memarr [64];
  logic [31:0] d1;
  logic [31:0] d3 [3];

  function automatic logic [31:0] mem_read(input logic [31:0] addr);
    return memarr[6'((addr - FB) >> 2)];
  endfunction

  always @(posedge clk) begin
    d1    <= mem_read(m1.mem_addr);
    d3[0] <= mem_read(m3.mem_addr);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign m1.mem_data = d1;
  assign m3.mem_data = d3[2];

  // Input history, one entry per clock; reset overwrites recent entries with idle values.
  bit          h_hs [MAXS];
  bit          h_vs [MAXS];
  bit          h_da [MAXS];
  bit          h_rd [MAXS];
  logic [31:0] h_va [MAXS];
  int          k;
  int          total, bad;
  int          lat [2] = '{1, 3};
  logic [31:0] exp_addr;
  logic [15:0] efr [2];
  logic [15:0] efe [2];
  logic [15:0] erun [2];

  function automatic bit gvs(input int i);
    return (i < 0) ? 1'b1 : h_vs[i];
  endfunction
  function automatic bit ghs(input int i);
    return (i < 0) ? 1'b1 : h_hs[i];
  endfunction
  function automatic bit gda(input int i);
    return (i < 0) ? 1'b0 : h_da[i];
  endfunction
  function automatic bit grd(input int i);
    return (i < 0) ? 1'b0 : h_rd[i];
  endfunction
  function automatic logic [31:0] gva(input int i);
    return (i < 0) ? 32'd0 : h_va[i];
  endfunction

  function automatic logic [7:0] pix_of(input int i);
    logic [31:0] a;
    a = gva(i);
    return 8'(memarr[6'(a >> 2)] >> (32'd8 * 32'(a[1:0])));
  endfunction

  // A 2-bit field repeated across 4 bits equals the field times 5.
  function automatic logic [3:0] chan(input logic [7:0] p, input int sh);
    return 4'(((32'(p) >> sh) & 32'd3) * 32'd5);
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] a, input bit inc);
    return (a == 16'hFFFF) ? a : a + 16'(inc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit hs, input bit vs, input bit da,
                      input logic [31:0] va);
    int          i;
    bit          rdp;
    logic [7:0]  p;
    logic [3:0]  o_r, o_g, o_b;
    logic        o_hs, o_vs;
    logic [15:0] o_fc, o_fe;
    reset = rst; hs_in = hs; vs_in = vs; da_in = da; vaddr_in = va;
    @(posedge clk);
    #1;
    rdp = grd(k - 1);
    if (rst) begin
      for (int j = k - 5; j <= k; j++) begin
        if (j >= 0) begin
          h_hs[j] = 1'b1; h_vs[j] = 1'b1; h_da[j] = 1'b0; h_rd[j] = 1'b0; h_va[j] = '0;
        end
      end
      exp_addr = FB;
      for (int d = 0; d < 2; d++) begin
        efr[d] = '0; efe[d] = '0; erun[d] = '0;
      end
    end else begin
      h_hs[k] = hs; h_vs[k] = vs; h_da[k] = da; h_va[k] = va;
      // Fetch whenever a display run starts or the pixel moves to another word.
      h_rd[k] = da && (!gda(k - 1) || (va >> 2) != (gva(k - 1) >> 2));
      if (da) exp_addr = FB + {va[31:2], 2'b00};
      for (int d = 0; d < 2; d++) begin
        if (gvs(k - lat[d] - 2) && !gvs(k - lat[d] - 1)) begin
          efr[d]  = efr[d] + 16'd1;
          efe[d]  = sat(erun[d], rdp);
          erun[d] = 16'(rdp);
        end else begin
          erun[d] = sat(erun[d], rdp);
        end
      end
    end
    chk("L1_mem_rd", 32'(m1.mem_rd), 32'(h_rd[k]));
    chk("L3_mem_rd", 32'(m3.mem_rd), 32'(h_rd[k]));
    chk("L1_mem_addr", m1.mem_addr, exp_addr);
    chk("L3_mem_addr", m3.mem_addr, exp_addr);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        o_r = r1; o_g = g1; o_b = b1; o_hs = hs1; o_vs = vs1; o_fc = fc1; o_fe = fe1;
      end else begin
        o_r = r3; o_g = g3; o_b = b3; o_hs = hs3; o_vs = vs3; o_fc = fc3; o_fe = fe3;
      end
      i = k - lat[d] - 1;
      p = gda(i) ? pix_of(i) : 8'd0;
      chk($sformatf("L%0d_R@%0d", lat[d], k), 32'(o_r), 32'(chan(p, 4)));
      chk($sformatf("L%0d_G@%0d", lat[d], k), 32'(o_g), 32'(chan(p, 2)));
      chk($sformatf("L%0d_B@%0d", lat[d], k), 32'(o_b), 32'(chan(p, 0)));
      chk($sformatf("L%0d_HS@%0d", lat[d], k), 32'(o_hs), 32'(ghs(i)));
      chk($sformatf("L%0d_VS@%0d", lat[d], k), 32'(o_vs), 32'(gvs(i)));
      chk($sformatf("L%0d_frame_cnt", lat[d]), 32'(o_fc), 32'(efr[d]));
      chk($sformatf("L%0d_fetch_cnt", lat[d]), 32'(o_fe), 32'(efe[d]));
    end
    k++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] va;
    total = 0; bad = 0; k = 0;
    for (int i = 0; i < 64; i++) memarr[i] = $urandom;
    memarr[0] = 32'h3F30_0C03;
    memarr[1] = 32'h0000_0030;

    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    idle(10);
    chk("idle_addr", m1.mem_addr, 32'h200);
    chk("idle_hs", 32'(hs1), 32'd1);

    // Eight pixels covering words 0 and 1.
    for (int p = 0; p < 8; p++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'(p));
      if (p == 0) chk("rd_v0_addr", m1.mem_addr, 32'h200);
      if (p == 1) chk("rd_v1_none", 32'(m1.mem_rd), 32'd0);
      if (p == 4) chk("rd_v4_addr", m1.mem_addr, 32'h204);
    end
    idle(6);

    // Two short lines in the same word: the second line must refetch.
    for (int p = 0; p < 4; p++) step(1'b0, 1'b1, 1'b1, 1'b1, 32'(p));
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'd0);
    chk("line2_first_rd", 32'(m1.mem_rd), 32'd1);
    for (int p = 1; p < 4; p++) step(1'b0, 1'b1, 1'b1, 1'b1, 32'(p));
    idle(6);

    // Single-cycle sync pulses.
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    idle(8);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    idle(8);

    // Three frames of two 160-pixel lines after a fresh reset.
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    idle(4);
    for (int f = 1; f <= 3; f++) begin
      for (int ln = 0; ln < 2; ln++) begin
        for (int p = 0; p < 160; p++) step(1'b0, 1'b1, 1'b1, 1'b1, 32'(p));
        for (int b = 0; b < 8; b++) step(1'b0, !(b >= 2 && b < 6), 1'b1, 1'b0, 32'd0);
      end
      repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      idle(10);
      chk("frame_cnt_L1", 32'(fc1), 32'(f));
      chk("frame_cnt_L3", 32'(fc3), 32'(f));
      chk("fetch_cnt_L1", 32'(fe1), 32'd80);
      chk("fetch_cnt_L3", 32'(fe3), 32'd80);
    end

    // Reset in the middle of a display line.
    for (int p = 0; p < 50; p++) step(1'b0, 1'b1, 1'b1, 1'b1, 32'(p));
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'd50);
    chk("midreset_hs", 32'(hs1), 32'd1);
    chk("midreset_frame", 32'(fc1), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'd51);
    chk("post_reset_rd", 32'(m1.mem_rd), 32'd1);
    for (int p = 52; p < 80; p++) step(1'b0, 1'b1, 1'b1, 1'b1, 32'(p));
    idle(6);

    // Address changes outside the display area.
    for (int n = 0; n < 20; n++) step(1'b0, 1'b1, 1'b1, 1'b0, $urandom);
    idle(6);

    // Random display runs with word jumps and hsync noise.
    va = $urandom;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) va = $urandom;
      else va = va + 32'd1;
      step(1'b0, $urandom_range(0, 9) != 0, 1'b1, $urandom_range(0, 3) != 0, va);
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
